// File: rtl/alpha_pkg.sv
// Shared constants for the alpha FIFO controller and its storage.
package alpha_pkg;

    // Default pixel/alpha word width in bits.
    localparam int ALPHA_DATA_WIDTH    = 10;

    // Default RAM address width; RAM depth is 2**ALPHA_ADDRESS_WIDTH.
    localparam int ALPHA_ADDRESS_WIDTH = 10;

    // Number of entries in the output stage (head + skid register).
    localparam int ALPHA_OSTAGE_DEPTH  = 2;

endpackage : alpha_pkg

// File: rtl/alpha_fifo_ram.sv
// Simple dual-port storage for the alpha FIFO.
// Write port A is synchronous. Read port B registers its address, and the
// data for that address is valid in the cycle after the address edge.
// Contents are never cleared; the controller tracks which words are live.
module alpha_fifo_ram
    import alpha_pkg::*;
#(
    parameter int DATA_WIDTH    = ALPHA_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = ALPHA_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [ADDRESS_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic                     i_rd_en,
    input  logic [ADDRESS_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0]    o_rd_data
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0]    r_mem [0:DEPTH-1];
    logic [ADDRESS_WIDTH-1:0] r_rd_addr;

    // Write port A and the registered read address of port B.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_addr <= i_rd_addr;
        end
    end

    assign o_rd_data = r_mem[r_rd_addr];

endmodule : alpha_fifo_ram

// File: rtl/alpha_fifo_ctrl.sv
// First-word-fall-through FIFO controller wrapped around a simple dual-port
// RAM. RAM reads are prefetched into a two-entry output stage (head + skid),
// so total capacity is DEPTH + 2 and a full-rate stream sustains one word
// per cycle. in_ready depends only on registered state plus reset/flush,
// never on out_ready.
module alpha_fifo_ctrl
    import alpha_pkg::*;
#(
    parameter int DATA_WIDTH    = ALPHA_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = ALPHA_ADDRESS_WIDTH,
    parameter int AFULL_LEVEL   = (1 << ADDRESS_WIDTH) - 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH+1:0] level,
    output logic                     almost_full,
    output logic                     empty
);

    localparam int                     DEPTH        = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] LP_DEPTH_PTR = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH+1:0] LP_AFULL   = (ADDRESS_WIDTH+2)'(AFULL_LEVEL);
    localparam logic [2:0]             LP_OSTAGE    = 3'(ALPHA_OSTAGE_DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [ADDRESS_WIDTH:0]   r_wr_ptr;
    logic [ADDRESS_WIDTH:0]   r_rd_ptr;
    logic                     r_inflight;
    logic                     r_head_v;
    logic                     r_skid_v;
    logic [DATA_WIDTH-1:0]    r_head;
    logic [DATA_WIDTH-1:0]    r_skid;
    logic [ADDRESS_WIDTH+1:0] r_level;
    logic                     r_afull;
    logic                     r_empty;

    logic [ADDRESS_WIDTH:0]   w_ram_count;
    logic                     w_ram_full;
    logic                     w_push;
    logic                     w_pop;
    logic [2:0]               w_stage_sum;
    logic                     w_rd_issue;
    logic                     w_ram_rd_en;
    logic [ADDRESS_WIDTH+1:0] w_level_nxt;
    logic [DATA_WIDTH-1:0]    w_ram_rd_data;

    assign w_ram_count = r_wr_ptr - r_rd_ptr;
    assign w_ram_full  = (w_ram_count == LP_DEPTH_PTR);
    assign in_ready    = ~reset & ~flush & ~w_ram_full;

    // Handshakes, the prefetch decision and the next occupancy value.
    always_comb begin
        w_push      = in_valid & in_ready;
        w_pop       = r_head_v & out_ready;
        w_stage_sum = {2'b00, r_head_v} + {2'b00, r_skid_v} + {2'b00, r_inflight};
        // Read only when the output stage will still have a free slot for
        // the returning word after this cycle's pop.
        if ((w_ram_count != {(ADDRESS_WIDTH+1){1'b0}}) &&
            ((w_stage_sum - {2'b00, w_pop}) < LP_OSTAGE)) begin
            w_rd_issue = 1'b1;
        end else begin
            w_rd_issue = 1'b0;
        end
        w_ram_rd_en = w_rd_issue & ~reset & ~flush;
        w_level_nxt = r_level + {{(ADDRESS_WIDTH+1){1'b0}}, w_push}
                              - {{(ADDRESS_WIDTH+1){1'b0}}, w_pop};
    end

    // Write/read pointers and the in-flight read flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= {(ADDRESS_WIDTH+1){1'b0}};
            r_rd_ptr   <= {(ADDRESS_WIDTH+1){1'b0}};
            r_inflight <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= {(ADDRESS_WIDTH+1){1'b0}};
            r_rd_ptr   <= {(ADDRESS_WIDTH+1){1'b0}};
            r_inflight <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{ADDRESS_WIDTH{1'b0}}, 1'b1};
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + {{ADDRESS_WIDTH{1'b0}}, 1'b1};
            end
            r_inflight <= w_rd_issue;
        end
    end

    // Two-entry output stage: head drives the output, skid absorbs the
    // word returning from RAM while the head is stalled.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_head   <= {DATA_WIDTH{1'b0}};
            r_skid   <= {DATA_WIDTH{1'b0}};
        end else begin
            case ({w_pop, r_inflight})
                2'b01: begin
                    if (!r_head_v) begin
                        r_head   <= w_ram_rd_data;
                        r_head_v <= 1'b1;
                    end else begin
                        r_skid   <= w_ram_rd_data;
                        r_skid_v <= 1'b1;
                    end
                end
                2'b10: begin
                    if (r_skid_v) begin
                        r_head   <= r_skid;
                        r_skid_v <= 1'b0;
                    end else begin
                        r_head_v <= 1'b0;
                    end
                end
                2'b11: begin
                    if (r_skid_v) begin
                        r_head <= r_skid;
                        r_skid <= w_ram_rd_data;
                    end else begin
                        r_head <= w_ram_rd_data;
                    end
                end
                default: begin
                    r_head_v <= r_head_v;
                    r_skid_v <= r_skid_v;
                end
            endcase
        end
    end

    // Occupancy counter and the flags derived from it.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_level <= {(ADDRESS_WIDTH+2){1'b0}};
            r_afull <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_level <= w_level_nxt;
            r_afull <= (w_level_nxt >= LP_AFULL);
            r_empty <= (w_level_nxt == {(ADDRESS_WIDTH+2){1'b0}});
        end
    end

    alpha_fifo_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr[ADDRESS_WIDTH-1:0]),
        .i_wr_data (in_data),
        .i_rd_en   (w_ram_rd_en),
        .i_rd_addr (r_rd_ptr[ADDRESS_WIDTH-1:0]),
        .o_rd_data (w_ram_rd_data)
    );

    assign out_valid   = r_head_v;
    assign out_data    = r_head;
    assign level       = r_level;
    assign almost_full = r_afull;
    assign empty       = r_empty;

endmodule : alpha_fifo_ctrl

// File: tb/tb_alpha_fifo_ctrl.sv
// Self-checking bench for alpha_fifo_ctrl. A queue of accepted words (each
// tagged with the edge it was accepted on) is the reference: level is the
// queue size, out_data must be the oldest word, and out_valid must be high
// exactly when the oldest word was accepted at least two edges ago.
module tb_alpha_fifo_ctrl;

    localparam int DW    = 10;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int AFULL = DEPTH - 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW+1:0] level;
    logic          almost_full;
    logic          empty;

    always #5 clk = ~clk;

    alpha_fifo_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .almost_full (almost_full),
        .empty       (empty)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    ent_t          q[$];
    int            edge_n      = 0;
    int            vectors     = 0;
    int            miscompares = 0;
    int            pops        = 0;
    logic          prev_stall  = 1'b0;
    logic [DW-1:0] prev_data   = '0;
    logic          last_push   = 1'b0;
    logic          last_pop    = 1'b0;
    logic [DW-1:0] last_pop_data = '0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: dut=%0h expected=%0h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    task automatic check_outputs();
        int   n;
        logic ev;
        n  = q.size();
        ev = (n > 0) && (q[0].t <= edge_n - 2);
        chk("level", int'(level), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("almost_full", int'(almost_full), int'(n >= AFULL));
        chk("out_valid", int'(out_valid), int'(ev));
        if (out_valid && n > 0) chk("out_data", int'(out_data), int'(q[0].d));
        if (prev_stall) chk("stall_hold", int'(out_data), int'(prev_data));
    endtask

    // One clock: drive inputs, sample handshakes, update the model at the
    // edge, then compare on the falling edge.
    task automatic cycle(input logic iv, input logic [DW-1:0] id,
                         input logic ordy, input logic fl, input logic rs);
        logic push;
        logic pop;
        ent_t e;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        #1;
        if (rs || fl)                chk("in_ready_blocked", int'(in_ready), 0);
        else if (q.size() < DEPTH)   chk("in_ready_open", int'(in_ready), 1);
        else if (q.size() >= DEPTH + 2) chk("in_ready_full", int'(in_ready), 0);
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready && !rs;
        prev_stall = out_valid && !out_ready && !rs && !fl;
        prev_data  = out_data;
        last_push  = push;
        last_pop   = pop;
        if (pop) last_pop_data = out_data;
        @(posedge clk);
        edge_n++;
        if (pop) pops++;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (pop && q.size() > 0) q.delete(0);
            if (push) begin
                e.d = id;
                e.t = edge_n;
                q.push_back(e);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain_all();
        for (int k = 0; k < DEPTH + 20 && q.size() != 0; k++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_empty", int'(level), 0);
    endtask

    initial begin
        int acc;
        int idx;
        int got;
        int p0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_afull", int'(almost_full), 0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_in_ready_after", int'(in_ready), 1);

        // Single word latency
        cycle(1'b1, 10'h155, 1'b1, 1'b0, 1'b0);
        chk("sw_valid_e", int'(out_valid), 0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("sw_valid_e1", int'(out_valid), 0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("sw_valid_e2", int'(out_valid), 1);
        chk("sw_data", int'(out_data), 'h155);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("sw_popped", int'(last_pop_data), 'h155);
        chk("sw_empty", int'(empty), 1);

        // Fill to capacity with the consumer stalled
        acc = 0;
        for (int i = 0; i < DEPTH + 6; i++) begin
            cycle(1'b1, DW'(acc), 1'b0, 1'b0, 1'b0);
            if (last_push) acc++;
        end
        chk("fill_accepts", acc, DEPTH + 2);
        chk("fill_level", int'(level), DEPTH + 2);
        chk("fill_afull", int'(almost_full), 1);
        chk("fill_in_ready", int'(in_ready), 0);
        idx = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (last_pop) begin
                chk("drain_order", int'(last_pop_data), idx % DEPTH);
                idx++;
            end
        end
        chk("drain_count", idx, DEPTH + 2);
        chk("drain_level", int'(level), 0);

        // Full-rate stream across several pointer wraps
        p0  = pops;
        idx = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
            if (last_pop) begin
                chk("stream_order", int'(last_pop_data), idx % DEPTH);
                idx++;
            end
        end
        chk("stream_pops", pops - p0, 3 * DEPTH - 3);
        chk("stream_level", int'(level), 3);
        drain_all();

        // Random traffic with occasional flush
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 199) == 0), 1'b0);
        end
        drain_all();

        // Flush with seven words stored and a word on offer
        for (int i = 0; i < 7; i++) cycle(1'b1, DW'(i + 'h40), 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("fl_level_before", int'(level), 7);
        cycle(1'b1, 10'h2AA, 1'b0, 1'b1, 1'b0);
        chk("fl_level_after", int'(level), 0);
        chk("fl_out_valid", int'(out_valid), 0);
        cycle(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0);
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (last_pop) begin
                got = 1;
                chk("fl_next_word", int'(last_pop_data), 'h3FF);
            end
        end
        if (got == 0) chk("fl_timeout", 0, 1);

        // Reset in the middle of traffic
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'(i + 'h80), 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rs_level_before", int'(level), 20);
        cycle(1'b1, 10'h123, 1'b1, 1'b0, 1'b1);
        chk("rs_level", int'(level), 0);
        chk("rs_empty", int'(empty), 1);
        chk("rs_afull", int'(almost_full), 0);
        chk("rs_out_valid", int'(out_valid), 0);
        chk("rs_out_data", int'(out_data), 0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 10'h001, 1'b1, 1'b0, 1'b0);
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (last_pop) begin
                got = 1;
                chk("rs_first_word", int'(last_pop_data), 'h001);
            end
        end
        if (got == 0) chk("rs_timeout", 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alpha_fifo_ctrl
